// File: rtl/token_arbiter.sv
// -----------------------------------------------------------------------------
// token_arbiter
//
// Purpose:
//   Control sequencer for the ring router core. Decides when this node holds
//   the ring token, when the node buffer is transmitted, and what the master
//   mux sends (buffer, forwarded RX word, TOKEN, ACK, NACK). A transmitted
//   buffer is retried on NACK or on an ACK timeout until MAX_RETRY
//   retransmissions have been made. After that the packet is dropped and the
//   token is passed on.
//
// Parameters:
//   OUR_ADDRESS  node address matched against the decoded destination
//   TIMEOUT      cycles spent in WAIT_ACK before a retry (1..65535)
//   MAX_RETRY    retransmissions after the first send before a drop (1..15)
//   INIT_TOKEN   1: this node injects the ring token after reset
//
// Ports:
//   i_clk                    clock
//   i_rst_n                  asynchronous reset, active low
//   i_rx_has_data            rx handshake holds a received word (level)
//   i_data_type[2:0]         decoded type: 111 TOKEN, 000 ACK, 011 NACK, else DATA
//   i_address[3:0]           decoded destination address
//   i_bad_decode             decoded word failed its check
//   i_tx_ready               tx handshake accepted the current word (1 cycle)
//   i_packet_from_node_valid node offers a packet to load
//   o_rc_ready               1-cycle pulse: rx word consumed
//   o_rc_has_data            request tx of the mux output, held until i_tx_ready
//   o_tx_data_select[2:0]    mux select: 0 buffer, 1 RX, 2 TOKEN, 3 ACK, 4 NACK
//   o_buffer_select          1-cycle pulse: load encoded node packet into buffer
//   o_core_load_ack          1-cycle pulse, coincident with o_buffer_select
//   o_packet_to_node_valid   1-cycle pulse: good DATA for this node delivered
//   o_token_held             high while in SEND, WAIT_ACK or PASS
//   o_drop_pulse             1-cycle pulse: packet abandoned after MAX_RETRY
// -----------------------------------------------------------------------------
module token_arbiter #(
    parameter logic [3:0]  OUR_ADDRESS = 4'b0000,
    parameter int unsigned TIMEOUT     = 1024,
    parameter int unsigned MAX_RETRY   = 3,
    parameter bit          INIT_TOKEN  = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_has_data,
    input  logic [2:0] i_data_type,
    input  logic [3:0] i_address,
    input  logic       i_bad_decode,
    input  logic       i_tx_ready,
    input  logic       i_packet_from_node_valid,
    output logic       o_rc_ready,
    output logic       o_rc_has_data,
    output logic [2:0] o_tx_data_select,
    output logic       o_buffer_select,
    output logic       o_core_load_ack,
    output logic       o_packet_to_node_valid,
    output logic       o_token_held,
    output logic       o_drop_pulse
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_REPLY    = 3'd1;
    localparam logic [2:0] S_SEND     = 3'd2;
    localparam logic [2:0] S_WAIT_ACK = 3'd3;
    localparam logic [2:0] S_PASS     = 3'd4;

    localparam logic [2:0] TYPE_TOKEN = 3'b111;
    localparam logic [2:0] TYPE_ACK   = 3'b000;
    localparam logic [2:0] TYPE_NACK  = 3'b011;

    localparam logic [2:0] SEL_BUF   = 3'd0;
    localparam logic [2:0] SEL_RX    = 3'd1;
    localparam logic [2:0] SEL_TOKEN = 3'd2;
    localparam logic [2:0] SEL_ACK   = 3'd3;
    localparam logic [2:0] SEL_NACK  = 3'd4;

    localparam logic [15:0] TIMER_LAST  = 16'(TIMEOUT - 1);
    localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRY);
    localparam logic [2:0]  RESET_STATE = INIT_TOKEN ? S_PASS : S_IDLE;

    // State and bookkeeping registers
    logic [2:0]  r_state;
    logic        r_buf_full;
    logic [15:0] r_timer;
    logic [3:0]  r_retry;

    // Registered outputs
    logic        r_rc_ready;
    logic        r_rc_has_data;
    logic [2:0]  r_tx_data_select;
    logic        r_buffer_select;
    logic        r_packet_to_node_valid;
    logic        r_token_held;
    logic        r_drop_pulse;

    // Decode helpers
    logic w_rx_eval;
    logic w_tx_done;
    logic w_is_token;
    logic w_is_ack;
    logic w_is_nack;
    logic w_is_data;
    logic w_for_us;
    logic w_timeout;
    logic w_load;

    // Next-state values
    logic [2:0]  w_state_next;
    logic [2:0]  w_sel_next;
    logic [15:0] w_timer_next;
    logic [3:0]  w_retry_next;
    logic        w_rc_ready_next;
    logic        w_ptn_valid_next;
    logic        w_drop_next;
    logic        w_buf_clear;
    logic        w_rc_has_data_next;
    logic        w_token_held_next;

    // While rc_ready is high the rx handshake still shows the word being
    // consumed; blanking that cycle stops the same word being acted on twice.
    assign w_rx_eval  = i_rx_has_data && !r_rc_ready;
    assign w_tx_done  = r_rc_has_data && i_tx_ready;
    assign w_is_token = (i_data_type == TYPE_TOKEN);
    assign w_is_ack   = (i_data_type == TYPE_ACK);
    assign w_is_nack  = (i_data_type == TYPE_NACK);
    assign w_is_data  = !(w_is_token || w_is_ack || w_is_nack);
    assign w_for_us   = w_is_data && (i_address == OUR_ADDRESS);
    assign w_timeout  = (r_timer == TIMER_LAST);
    // A full buffer blocks new loads, so a load can never overlap the send
    // of the buffer contents.
    assign w_load     = i_packet_from_node_valid && !r_buf_full;

    always_comb begin
        w_state_next     = r_state;
        w_sel_next       = r_tx_data_select;
        w_timer_next     = r_timer;
        w_retry_next     = r_retry;
        w_rc_ready_next  = 1'b0;
        w_ptn_valid_next = 1'b0;
        w_drop_next      = 1'b0;
        w_buf_clear      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_rx_eval) begin
                    if (w_is_token && r_buf_full) begin
                        // Token captured: it is consumed now and re-issued from PASS.
                        w_rc_ready_next = 1'b1;
                        w_retry_next    = 4'd0;
                        w_state_next    = S_SEND;
                        w_sel_next      = SEL_BUF;
                    end else begin
                        w_state_next = S_REPLY;
                        if (w_is_token) begin
                            w_sel_next = SEL_TOKEN;
                        end else if (w_for_us && !i_bad_decode) begin
                            w_ptn_valid_next = 1'b1;
                            w_sel_next       = SEL_ACK;
                        end else if (w_for_us) begin
                            w_sel_next = SEL_NACK;
                        end else begin
                            w_sel_next = SEL_RX;
                        end
                    end
                end
            end

            S_REPLY: begin
                // The rx word is released only once its reply has gone out.
                if (w_tx_done) begin
                    w_rc_ready_next = 1'b1;
                    w_state_next    = S_IDLE;
                end
            end

            S_SEND: begin
                if (w_tx_done) begin
                    w_state_next = S_WAIT_ACK;
                    w_timer_next = 16'd0;
                end
            end

            S_WAIT_ACK: begin
                w_timer_next = r_timer + 16'd1;
                if (w_rx_eval && w_is_ack) begin
                    w_rc_ready_next = 1'b1;
                    w_buf_clear     = 1'b1;
                    w_state_next    = S_PASS;
                    w_sel_next      = SEL_TOKEN;
                end else if ((w_rx_eval && w_is_nack) || w_timeout) begin
                    // NACK and timeout in the same cycle count as one retry.
                    w_rc_ready_next = w_rx_eval && w_is_nack;
                    if (r_retry < RETRY_LIMIT) begin
                        w_retry_next = r_retry + 4'd1;
                        w_state_next = S_SEND;
                        w_sel_next   = SEL_BUF;
                    end else begin
                        w_drop_next  = 1'b1;
                        w_buf_clear  = 1'b1;
                        w_state_next = S_PASS;
                        w_sel_next   = SEL_TOKEN;
                    end
                end else if (w_rx_eval) begin
                    // Unrelated traffic while waiting is swallowed; the timer keeps running.
                    w_rc_ready_next = 1'b1;
                end
            end

            S_PASS: begin
                // Also reached straight out of reset when this node injects the token.
                w_sel_next = SEL_TOKEN;
                if (w_tx_done) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_rc_has_data_next = (w_state_next == S_REPLY) ||
                                (w_state_next == S_SEND)  ||
                                (w_state_next == S_PASS);
    assign w_token_held_next  = (w_state_next == S_SEND)     ||
                                (w_state_next == S_WAIT_ACK) ||
                                (w_state_next == S_PASS);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state                <= RESET_STATE;
            r_buf_full             <= 1'b0;
            r_timer                <= 16'd0;
            r_retry                <= 4'd0;
            r_rc_ready             <= 1'b0;
            r_rc_has_data          <= 1'b0;
            r_tx_data_select       <= SEL_BUF;
            r_buffer_select        <= 1'b0;
            r_packet_to_node_valid <= 1'b0;
            r_token_held           <= 1'b0;
            r_drop_pulse           <= 1'b0;
        end else begin
            r_state                <= w_state_next;
            r_timer                <= w_timer_next;
            r_retry                <= w_retry_next;
            r_rc_ready             <= w_rc_ready_next;
            r_rc_has_data          <= w_rc_has_data_next;
            r_tx_data_select       <= w_sel_next;
            r_buffer_select        <= w_load;
            r_packet_to_node_valid <= w_ptn_valid_next;
            r_token_held           <= w_token_held_next;
            r_drop_pulse           <= w_drop_next;
            if (w_load) begin
                r_buf_full <= 1'b1;
            end else if (w_buf_clear) begin
                r_buf_full <= 1'b0;
            end
        end
    end

    assign o_rc_ready             = r_rc_ready;
    assign o_rc_has_data          = r_rc_has_data;
    assign o_tx_data_select       = r_tx_data_select;
    assign o_buffer_select        = r_buffer_select;
    assign o_core_load_ack        = r_buffer_select;
    assign o_packet_to_node_valid = r_packet_to_node_valid;
    assign o_token_held           = r_token_held;
    assign o_drop_pulse           = r_drop_pulse;

endmodule

// File: tb/tb_token_arbiter.sv
// -----------------------------------------------------------------------------
// tb_token_arbiter
//
// Directed bench for token_arbiter (TIMEOUT=16, MAX_RETRY=3, address 0).
// Every rx word driven pushes the mux select expected for the resulting
// transmission onto a queue; each tx request from the DUT pops and compares.
// Pulse outputs are tallied by counters and compared as deltas per scenario.
// -----------------------------------------------------------------------------
module tb_token_arbiter;

    localparam logic [2:0] T_TOKEN = 3'b111;
    localparam logic [2:0] T_ACK   = 3'b000;
    localparam logic [2:0] T_NACK  = 3'b011;
    localparam logic [2:0] T_DATA  = 3'b001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_has_data = 1'b0;
    logic [2:0] data_type = 3'd0;
    logic [3:0] address = 4'd0;
    logic       bad_decode = 1'b0;
    logic       tx_ready = 1'b0;
    logic       pkt_valid = 1'b0;

    logic       rc_ready;
    logic       rc_has_data;
    logic [2:0] tx_sel;
    logic       buffer_select;
    logic       core_load_ack;
    logic       ptn_valid;
    logic       token_held;
    logic       drop_pulse;

    always #5 clk = ~clk;

    token_arbiter #(
        .OUR_ADDRESS (4'b0000),
        .TIMEOUT     (16),
        .MAX_RETRY   (3),
        .INIT_TOKEN  (1'b0)
    ) dut (
        .i_clk                    (clk),
        .i_rst_n                  (rst_n),
        .i_rx_has_data            (rx_has_data),
        .i_data_type              (data_type),
        .i_address                (address),
        .i_bad_decode             (bad_decode),
        .i_tx_ready               (tx_ready),
        .i_packet_from_node_valid (pkt_valid),
        .o_rc_ready               (rc_ready),
        .o_rc_has_data            (rc_has_data),
        .o_tx_data_select         (tx_sel),
        .o_buffer_select          (buffer_select),
        .o_core_load_ack          (core_load_ack),
        .o_packet_to_node_valid   (ptn_valid),
        .o_token_held             (token_held),
        .o_drop_pulse             (drop_pulse)
    );

    wire [9:0] all_outs = {rc_ready, rc_has_data, tx_sel, buffer_select,
                           core_load_ack, ptn_valid, token_held, drop_pulse};

    int errors = 0;
    int checks = 0;
    logic [2:0] exp_q[$];

    int cnt_drop = 0;
    int cnt_ptn = 0;
    int cnt_load = 0;
    int cnt_bufsend = 0;

    always @(posedge clk) begin
        if (drop_pulse)    cnt_drop    <= cnt_drop + 1;
        if (ptn_valid)     cnt_ptn     <= cnt_ptn + 1;
        if (buffer_select) cnt_load    <= cnt_load + 1;
        if (rc_has_data && tx_ready && tx_sel == 3'd0) cnt_bufsend <= cnt_bufsend + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; the rx source withdraws its word once it sees rc_ready.
    task automatic step();
        @(posedge clk);
        #1;
        if (rc_ready) rx_has_data = 1'b0;
    endtask

    task automatic send_rx(input logic [2:0] t, input logic [3:0] a, input logic bad,
                           input logic [2:0] exp_sel);
        data_type   = t;
        address     = a;
        bad_decode  = bad;
        rx_has_data = 1'b1;
        exp_q.push_back(exp_sel);
    endtask

    // Wait for a tx request, check select and hold, then accept it.
    task automatic wait_tx(input string tag);
        int n;
        logic [2:0] e;
        logic [2:0] sel0;
        n = 0;
        while (!rc_has_data && n < 64) begin
            step();
            n++;
        end
        chk({tag, "_req"}, {31'd0, rc_has_data}, 32'd1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = 3'bxxx;
        sel0 = tx_sel;
        chk({tag, "_sel"}, {29'd0, sel0}, {29'd0, e});
        step();
        chk({tag, "_hold"}, {28'd0, rc_has_data, tx_sel}, {28'd0, 1'b1, sel0});
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk({tag, "_done"}, {31'd0, rc_has_data}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int base_send;
        int base_drop;
        int base_ptn;
        int base_load;

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {22'd0, all_outs}, 32'd0);
        rst_n = 1'b1;
        step();
        step();

        // ---------------- 1: token with empty buffer is forwarded ----------------
        send_rx(T_TOKEN, 4'd0, 1'b0, 3'd2);
        wait_tx("t1_token");
        chk("t1_rc_ready", {31'd0, rc_ready}, 32'd1);
        step();
        chk("t1_rc_ready_pulse", {31'd0, rc_ready}, 32'd0);
        chk("t1_no_token", {31'd0, token_held}, 32'd0);

        // ---------------- 2: load, send, ACK, pass token ----------------
        pkt_valid = 1'b1;
        step();
        pkt_valid = 1'b0;
        chk("t2_load", {30'd0, buffer_select, core_load_ack}, 32'd3);
        step();
        chk("t2_load_pulse", {30'd0, buffer_select, core_load_ack}, 32'd0);
        send_rx(T_TOKEN, 4'd0, 1'b0, 3'd0);
        step();
        chk("t2_send_take", {29'd0, rc_ready, token_held, rc_has_data}, 32'd7);
        wait_tx("t2_send");
        chk("t2_wait_held", {31'd0, token_held}, 32'd1);
        send_rx(T_ACK, 4'd0, 1'b0, 3'd2);
        wait_tx("t2_pass");
        chk("t2_released", {31'd0, token_held}, 32'd0);
        chk("t2_bufsend", cnt_bufsend, 1);

        // ---------------- 3: NACK x4 -> 4 sends, one drop ----------------
        base_send = cnt_bufsend;
        base_drop = cnt_drop;
        pkt_valid = 1'b1;
        step();
        pkt_valid = 1'b0;
        send_rx(T_TOKEN, 4'd0, 1'b0, 3'd0);
        wait_tx("t3_send0");
        for (int i = 0; i < 4; i++) begin
            send_rx(T_NACK, 4'd0, 1'b0, (i < 3) ? 3'd0 : 3'd2);
            wait_tx("t3_nack");
        end
        step();
        chk("t3_sends", cnt_bufsend - base_send, 4);
        chk("t3_drop", cnt_drop - base_drop, 1);
        chk("t3_token_released", {31'd0, token_held}, 32'd0);

        // ---------------- 4: timeout resend, NACK on timeout cycle ----------------
        base_send = cnt_bufsend;
        base_drop = cnt_drop;
        pkt_valid = 1'b1;
        step();
        pkt_valid = 1'b0;
        send_rx(T_TOKEN, 4'd0, 1'b0, 3'd0);
        wait_tx("t4_send0");
        n = 0;
        while (!rc_has_data && n < 40) begin
            step();
            n++;
        end
        chk("t4_timeout_cycles", n, 16);
        chk("t4_timeout_no_rc_ready", {31'd0, rc_ready}, 32'd0);
        exp_q.push_back(3'd0);
        wait_tx("t4_resend1");
        repeat (15) step();
        send_rx(T_NACK, 4'd0, 1'b0, 3'd0);
        step();
        chk("t4_nack_on_timeout", {30'd0, rc_ready, rc_has_data}, 32'd3);
        wait_tx("t4_resend2");
        send_rx(T_NACK, 4'd0, 1'b0, 3'd0);
        wait_tx("t4_resend3");
        send_rx(T_NACK, 4'd0, 1'b0, 3'd2);
        wait_tx("t4_drop_pass");
        step();
        chk("t4_sends", cnt_bufsend - base_send, 4);
        chk("t4_drop", cnt_drop - base_drop, 1);

        // ---------------- 5: DATA handling ----------------
        base_ptn = cnt_ptn;
        send_rx(T_DATA, 4'd0, 1'b0, 3'd3);
        wait_tx("t5_data_ack");
        chk("t5_deliver", cnt_ptn - base_ptn, 1);
        send_rx(T_DATA, 4'd0, 1'b1, 3'd4);
        wait_tx("t5_data_nack");
        send_rx(3'b010, 4'd5, 1'b0, 3'd1);
        wait_tx("t5_forward");
        send_rx(T_ACK, 4'd0, 1'b0, 3'd1);
        wait_tx("t5_stray_ack");
        step();
        chk("t5_deliver_total", cnt_ptn - base_ptn, 1);

        // ---------------- 6: load while full, async reset in WAIT_ACK ----------------
        base_load = cnt_load;
        pkt_valid = 1'b1;
        repeat (4) step();
        pkt_valid = 1'b0;
        step();
        chk("t6_single_load", cnt_load - base_load, 1);
        send_rx(T_TOKEN, 4'd0, 1'b0, 3'd0);
        wait_tx("t6_send");
        step();
        step();
        chk("t6_waiting", {30'd0, token_held, rc_has_data}, 32'd2);
        base_drop = cnt_drop;
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset", {22'd0, all_outs}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        send_rx(T_TOKEN, 4'd0, 1'b0, 3'd2);
        wait_tx("t6_buf_lost");
        step();
        chk("t6_no_drop", cnt_drop - base_drop, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
